// File: rtl/imm_gen_stage.sv
// Registered RV immediate-generation stage: decodes imm_type, forms the XLEN immediate, valid/ready output register.
// Define IMMGEN_SKID_EN to add a one-entry skid buffer so in_ready has no combinational path from out_ready.
module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [2:0]       imm_type,
    output logic [XLEN-1:0]  imm,
    output logic [CNT_W-1:0] x_count
);

    typedef enum logic [2:0] {
        T_R     = 3'd0,
        T_I     = 3'd1,
        T_ISTAR = 3'd2,
        T_S     = 3'd3,
        T_B     = 3'd4,
        T_U     = 3'd5,
        T_J     = 3'd6,
        T_X     = 3'd7
    } imm_type_e;

    imm_type_e               w_type;
    logic signed [31:0]      w_raw;
    logic signed [XLEN-1:0]  w_imm;
    logic                    w_accept;

    imm_type_e               r_imm_type;
    logic                    r_out_valid;
    logic [31:0]             r_out_inst;
    logic [XLEN-1:0]         r_imm;
    logic [CNT_W-1:0]        r_x_count;

    always_comb begin
        w_type = T_X;
        case (inst[6:0])
            7'b0110011: w_type = T_R;
            7'b0010011: begin
                if (inst[13:12] == 2'b01)
                    w_type = (XLEN == 32 && inst[25]) ? T_X : T_ISTAR;
                else
                    w_type = T_I;
            end
            7'b1100111, 7'b0000011: w_type = T_I;
            7'b0100011:             w_type = T_S;
            7'b1100011:             w_type = T_B;
            7'b0010111, 7'b0110111: w_type = T_U;
            7'b1101111:             w_type = T_J;
            default:                w_type = T_X;
        endcase
    end

    // Every form is built at 32 bits then sign-extended; ISTAR's inst[25:20] has zero
    // upper bits, and for XLEN=32 a set inst[25] already decodes to X.
    always_comb begin
        w_raw = '0;
        case (w_type)
            T_I:     w_raw = {{20{inst[31]}}, inst[31:20]};
            T_ISTAR: w_raw = {26'b0, inst[25:20]};
            T_S:     w_raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            T_B:     w_raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            T_U:     w_raw = {inst[31:12], 12'b0};
            T_J:     w_raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: w_raw = '0;
        endcase
        w_imm = w_raw;
    end

`ifdef IMMGEN_SKID_EN
    imm_type_e       r_skid_type;
    logic            r_skid_valid;
    logic [31:0]     r_skid_inst;
    logic [XLEN-1:0] r_skid_imm;

    assign in_ready = ~r_skid_valid;
    assign w_accept = in_valid & ~r_skid_valid & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_inst   <= '0;
            r_imm_type   <= T_X;
            r_imm        <= '0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= '0;
            r_skid_type  <= T_X;
            r_skid_imm   <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            // Skid entry is older than anything arriving now, so it drains first.
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_inst   <= r_skid_inst;
                r_imm_type   <= r_skid_type;
                r_imm        <= r_skid_imm;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_inst  <= inst;
                r_imm_type  <= w_type;
                r_imm       <= w_imm;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_inst  <= inst;
            r_skid_type  <= w_type;
            r_skid_imm   <= w_imm;
        end
    end
`else
    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_imm_type  <= T_X;
            r_imm       <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= inst;
            r_imm_type  <= w_type;
            r_imm       <= w_imm;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_x_count <= '0;
        else if (w_accept && w_type == T_X && r_x_count != '1)
            r_x_count <= r_x_count + CNT_W'(1);
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign imm_type  = r_imm_type;
    assign imm       = r_imm;
    assign x_count   = r_x_count;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage: default instance, CNT_W=2 saturation instance, XLEN=64 instance.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] inst = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_inst;
    logic [2:0]  imm_type;
    logic [31:0] imm;
    logic [15:0] x_count;

    logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic [31:0] s_inst = '0;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_inst;
    logic [2:0]  s_imm_type;
    logic [31:0] s_imm;
    logic [1:0]  s_x_count;

    logic        d_flush = 1'b0, d_in_valid = 1'b0, d_out_ready = 1'b0;
    logic [31:0] d_inst = '0;
    logic        d_in_ready, d_out_valid;
    logic [31:0] d_out_inst;
    logic [2:0]  d_imm_type;
    logic [63:0] d_imm;
    logic [15:0] d_x_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .imm_type(imm_type), .imm(imm), .x_count(x_count)
    );

    imm_gen_stage #(.XLEN(32), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .inst(s_inst), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_inst(s_out_inst),
        .imm_type(s_imm_type), .imm(s_imm), .x_count(s_x_count)
    );

    imm_gen_stage #(.XLEN(64), .CNT_W(16)) u_d64 (
        .clk(clk), .reset(reset), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .inst(d_inst), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_inst(d_out_inst),
        .imm_type(d_imm_type), .imm(d_imm), .x_count(d_x_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] ei, input logic [2:0] et,
                             input logic [31:0] em);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".inst"},  64'(out_inst),  64'(ei));
        check({tag, ".type"},  64'(imm_type),  64'(et));
        check({tag, ".imm"},   64'(imm),       64'(em));
    endtask

    initial begin
        tick();
        tick();
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.inst",  64'(out_inst),  64'd0);
        check("rst.type",  64'(imm_type),  64'd7);
        check("rst.imm",   64'(imm),       64'd0);
        check("rst.xcnt",  64'(x_count),   64'd0);
        check("rst.ready", 64'(in_ready),  64'd1);
        check("rst.d64imm", d_imm, 64'd0);

        reset = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; inst = 32'hFFF0_0093;
        tick();
        check_out("addi", 32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF);

        inst = 32'h1234_50B7;
        tick();
        check_out("lui", 32'h1234_50B7, 3'd5, 32'h1234_5000);
        inst = 32'hFE00_0EE3;
        tick();
        check_out("beq", 32'hFE00_0EE3, 3'd4, 32'hFFFF_FFFC);
        inst = 32'h0030_9093;
        tick();
        check_out("slli", 32'h0030_9093, 3'd2, 32'h0000_0003);

        inst = 32'hFFF0_0093;
        tick();
        check_out("stall.pre", 32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF);
        out_ready = 1'b0; inst = 32'h1234_50B7;
        #1;
`ifdef IMMGEN_SKID_EN
        check("stall.ready0", 64'(in_ready), 64'd1);
`else
        check("stall.ready0", 64'(in_ready), 64'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("stall.hold", 32'hFFF0_0093, 3'd1, 32'hFFFF_FFFF);
            check("stall.ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        check_out("release", 32'h1234_50B7, 3'd5, 32'h1234_5000);
        in_valid = 1'b0;
        tick();
        check("drain.valid", 64'(out_valid), 64'd0);

        in_valid = 1'b1; inst = 32'hFFF0_0093;
        tick();
        check("preflush.valid", 64'(out_valid), 64'd1);
        flush = 1'b1; inst = 32'h0000_0000;
        tick();
        check("flush.valid", 64'(out_valid), 64'd0);
        check("flush.xcnt",  64'(x_count),   64'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("postflush.valid", 64'(out_valid), 64'd0);
        check("postflush.xcnt",  64'(x_count),   64'd0);

        in_valid = 1'b1; inst = 32'h0000_0000;
        tick();
        check_out("ill0", 32'h0000_0000, 3'd7, 32'h0);
        check("ill0.xcnt", 64'(x_count), 64'd1);
        inst = 32'h0200_9093;
        tick();
        check_out("ill_shamt", 32'h0200_9093, 3'd7, 32'h0);
        check("ill_shamt.xcnt", 64'(x_count), 64'd2);
        in_valid = 1'b0;
        tick();
        check("idle.xcnt", 64'(x_count), 64'd2);

        s_in_valid = 1'b1; s_out_ready = 1'b1; s_inst = 32'h0000_0000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("sat.xcnt", 64'(s_x_count), (i < 3) ? 64'(i) : 64'd3);
        end
        check("sat.type", 64'(s_imm_type), 64'd7);
        s_in_valid = 1'b0;

        d_in_valid = 1'b1; d_out_ready = 1'b1; d_inst = 32'h8000_0037;
        tick();
        check("x64.lui.valid", 64'(d_out_valid), 64'd1);
        check("x64.lui.type",  64'(d_imm_type),  64'd5);
        check("x64.lui.imm",   d_imm,            64'hFFFF_FFFF_8000_0000);
        d_inst = 32'h03F0_9093;
        tick();
        check("x64.slli.type", 64'(d_imm_type),  64'd2);
        check("x64.slli.imm",  d_imm,            64'd63);
        check("x64.xcnt",      64'(d_x_count),   64'd0);
        d_in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered immediate-generation stage for stage1 decode.
- Decodes imm_type from a 32-bit RV instruction and forms the sign- or zero-extended immediate at XLEN width.
- Passes both through a valid/ready pipeline register with flush, plus a saturating counter of undecodable instructions.
- Sits between instruction fetch and the stage1 register-read/ALU-operand mux.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- CNT_W, 16, width of the saturating X_TYPE counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  kill the held entry and drop the incoming one this cycle.
- in_valid  input  1  inst is valid.
- in_ready  output  1  stage can accept inst this cycle.
- inst  input  32  instruction word.
- out_valid  output  1  registered outputs are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_inst  output  32  registered copy of inst.
- imm_type  output  3  stage1_control.vh encoding: R=0, I=1, ISTAR=2, S=3, B=4, U=5, J=6, X=7.
- imm  output  XLEN  formed immediate.
- x_count  output  CNT_W  count of accepted X_TYPE instructions, saturating.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_inst=0, imm_type=X (7), imm=0, x_count=0. Reset mid-transfer discards the held entry.
- Latency: 1 cycle from an accepted input to out_valid.
- Handshake:
  - Accept when in_valid & in_ready.
  - An output transfers when out_valid & out_ready.
  - While out_valid & ~out_ready, out_inst, imm_type and imm hold stable.
- in_ready (no macro) = ~out_valid | out_ready. This is a combinational path from out_ready.
- Simultaneous output transfer and input accept: the register is loaded with the new entry; out_valid stays 1.
- flush has priority over everything except reset:
  - Next cycle out_valid=0.
  - The input presented in the flush cycle is not accepted and not counted.
  - in_ready may be 1 during flush.
- Opcode to type decode:
  - 0110011 -> R.
  - 0010011 -> I, except funct3 001/101 -> ISTAR. When XLEN=32, ISTAR with inst[25]=1 -> X (illegal shamt).
  - 1100111 (JALR) and 0000011 (LOAD) -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0010111 (AUIPC) and 0110111 (LUI) -> U.
  - 1101111 -> J.
  - Every other opcode -> X.
- Immediate forms (sext/zext to XLEN):
  - I: sext inst[31:20].
  - ISTAR: zext inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64).
  - S: sext {inst[31:25], inst[11:7]}.
  - B: sext {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: sext {inst[31:12], 12'b0}.
  - J: sext {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R and X: imm=0.
- x_count increments by 1 on each accepted input decoded as X. It saturates at 2^CNT_W-1 and does not wrap. It is not cleared by flush.

Optional Feature:
- Macro IMMGEN_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer, so in_ready is a flop with no combinational path from out_ready.
  - in_ready = ~skid_valid.
  - Stall case: an input accepted while out_valid & ~out_ready goes to the skid buffer. The next output transfer moves the skid entry to the output register.
  - Ordering is strictly FIFO.
  - flush clears both the output register and the skid buffer.
  - Reset: skid_valid=0, in_ready=1 the cycle after reset deasserts.
  - x_count counts at acceptance, whether the entry lands in the skid buffer or the output register.
- Undefined: single register only, with in_ready as above.

Test Plan:
- Reset, then drive in_valid=1, out_ready=1, inst=0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, imm_type=1, imm=0xFFFFFFFF (XLEN=32).
- Back-to-back 0x123450B7, 0xFE000EE3, 0x00309093 with out_ready=1 -> consecutive outputs:
  - (5, 0x12345000)
  - (4, 0xFFFFFFFC)
  - (2, 0x00000003)
- Stall: out_ready=0 for 3 cycles with 0xFFF00093 held at the output -> outputs stable, in_ready=0 (no macro); with IMMGEN_SKID_EN, one extra input is absorbed, then in_ready=0, and order is preserved on release.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, the flushed input never appears, x_count unchanged.
- Illegal inputs: stream 0x00000000 and 0x02009093 (slli, inst[25]=1, XLEN=32) -> imm_type=7, imm=0, x_count increments once per accepted input. With CNT_W=2, five illegal accepts -> x_count saturates at 3.
- XLEN=64, inst=0x80000037 (lui x0,0x80000) -> imm_type=5, imm=0xFFFFFFFF80000000; 0x03F09093 -> imm_type=2, imm=63.
